// File: rtl/tanh_backward.sv
// -----------------------------------------------------------------------------
// tanh_backward
//
// Local gradient of the tanh activation for the backprop datapath:
//   deriv = 1 - y^2          (y = forward tanh output, clamped to [-1, +1])
//   grad  = delta * deriv
// All values are signed fixed point with FL fractional bits (Q8.24 by default).
// Every product is truncated toward negative infinity (arithmetic floor shift).
//
// Three-stage pipeline, one sample per enabled cycle:
//   stage 1 : clamp y, square it, capture delta
//   stage 2 : deriv = 1 - y^2, multiply by delta
//   stage 3 : output registers
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset, wins over en
//   en         in   pipeline advance; 0 holds every register (incl. valids)
//   in_valid   in   y_in / delta_in carry a sample this cycle
//   y_in       in   forward tanh output, signed Q(WIDTH-FL).FL
//   delta_in   in   upstream gradient, signed Q(WIDTH-FL).FL
//   out_valid  out  grad_out / deriv_out / clamp_flag are valid
//   grad_out   out  delta * (1 - y^2), signed
//   deriv_out  out  1 - y^2, range [0, 1.0]
//   clamp_flag out  y_in was outside [-1.0, +1.0] and got clamped
// -----------------------------------------------------------------------------
module tanh_backward #(
  parameter int WIDTH = 32,
  parameter int FL    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] delta_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] grad_out,
  output logic [WIDTH-1:0] deriv_out,
  output logic             clamp_flag
);

  localparam int PW = 2 * WIDTH;

  localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-FL-1){1'b0}}, 1'b1, {FL{1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

  // ---------------------------------------------------------------------------
  // Stage 1: clamp and square
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] y_s;
  logic signed [WIDTH-1:0] y_c;
  logic                    clamp_hi;
  logic                    clamp_lo;
  logic                    clamped;
  logic signed [PW-1:0]    y_c_ext;
  logic signed [PW-1:0]    sq_full;
  logic [WIDTH-1:0]        y_sq_d;

  assign y_s      = $signed(y_in);
  assign clamp_hi = (y_s > ONE);
  assign clamp_lo = (y_s < NEG_ONE);
  assign clamped  = clamp_hi | clamp_lo;

  always_comb begin
    y_c = y_s;
    if (clamp_hi) begin
      y_c = ONE;
    end else if (clamp_lo) begin
      y_c = NEG_ONE;
    end
  end

  // Explicit sign extension keeps the multiply a full-width signed product.
  assign y_c_ext = {{WIDTH{y_c[WIDTH-1]}}, y_c};
  assign sq_full = y_c_ext * y_c_ext;
  assign y_sq_d  = sq_full[FL+WIDTH-1:FL];

  logic [WIDTH-1:0] s1_ysq_q;
  logic [WIDTH-1:0] s1_delta_q;

  // ---------------------------------------------------------------------------
  // Stage 2: derivative and gradient product
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]     deriv_d;
  logic signed [PW-1:0] delta_ext;
  logic signed [PW-1:0] deriv_ext;
  logic signed [PW-1:0] prod_full;
  logic [WIDTH-1:0]     grad_d;

  // y_sq never exceeds 1.0 because y was clamped, so this cannot wrap.
  assign deriv_d   = ONE - s1_ysq_q;
  assign delta_ext = {{WIDTH{s1_delta_q[WIDTH-1]}}, s1_delta_q};
  assign deriv_ext = {{WIDTH{deriv_d[WIDTH-1]}}, deriv_d};
  assign prod_full = delta_ext * deriv_ext;
  // |deriv| <= 1.0, so the floor-shifted product always fits WIDTH bits.
  assign grad_d    = prod_full[FL+WIDTH-1:FL];

  logic [WIDTH-1:0] s2_deriv_q;
  logic [WIDTH-1:0] s2_grad_q;

  // ---------------------------------------------------------------------------
  // Stage 3: output registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s3_deriv_q;
  logic [WIDTH-1:0] s3_grad_q;

  // Valid and clamp-flag travel together through the three stages.
  // Index 0 is stage 1, index 2 is the output stage.
  logic [2:0] vld_q;
  logic [2:0] flg_q;
  logic [2:0] vld_d;
  logic [2:0] flg_d;

  always_comb begin
    vld_d = {vld_q[1:0], in_valid};
    flg_d = {flg_q[1:0], clamped & in_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ysq_q   <= '0;
      s1_delta_q <= '0;
      s2_deriv_q <= '0;
      s2_grad_q  <= '0;
      s3_deriv_q <= '0;
      s3_grad_q  <= '0;
      vld_q      <= '0;
      flg_q      <= '0;
    end else if (en) begin
      // Data registers load even for bubbles; only the valid bit marks them.
      s1_ysq_q   <= y_sq_d;
      s1_delta_q <= delta_in;
      s2_deriv_q <= deriv_d;
      s2_grad_q  <= grad_d;
      s3_deriv_q <= s2_deriv_q;
      s3_grad_q  <= s2_grad_q;
      vld_q      <= vld_d;
      flg_q      <= flg_d;
    end
  end

  assign out_valid  = vld_q[2];
  assign clamp_flag = flg_q[2];
  assign grad_out   = s3_grad_q;
  assign deriv_out  = s3_deriv_q;

  // Bits discarded by the fixed-point truncations.
  logic unused_bits;
  assign unused_bits = ^{sq_full[PW-1:FL+WIDTH], sq_full[FL-1:0],
                         prod_full[PW-1:FL+WIDTH], prod_full[FL-1:0]};

endmodule

// File: tb/tb_tanh_backward.sv
// -----------------------------------------------------------------------------
// tb_tanh_backward
//
// Self-checking bench for tanh_backward. Stimulus is driven just after each
// rising edge; expected results are queued when a sample is driven with en=1
// and popped when the DUT presents it. Outputs are sampled on the falling
// edge: after a reset edge they must be zero, after a stalled edge they must
// equal the previous sample, after an enabled edge a valid output is compared
// against the queue head, including the enabled-edge count at which it shows.
// -----------------------------------------------------------------------------
module tb_tanh_backward;

  localparam int WIDTH = 32;
  localparam int FL    = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] delta_in;
  logic             out_valid;
  logic [WIDTH-1:0] grad_out;
  logic [WIDTH-1:0] deriv_out;
  logic             clamp_flag;

  always #5 clk = ~clk;

  tanh_backward #(.WIDTH(WIDTH), .FL(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .y_in       (y_in),
    .delta_in   (delta_in),
    .out_valid  (out_valid),
    .grad_out   (grad_out),
    .deriv_out  (deriv_out),
    .clamp_flag (clamp_flag)
  );

  typedef struct {
    logic [31:0] deriv;
    logic [31:0] grad;
    logic        flag;
    int          tgt;
    int          id;
  } exp_t;

  typedef struct {
    logic [31:0] y;
    logic [31:0] d;
    logic [31:0] deriv;
    logic [31:0] grad;
    logic        flag;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   en_edges = 0;
  int   next_id  = 0;
  bit   loaded_last = 1'b0;
  bit   rst_last    = 1'b0;
  bit   seen_edge   = 1'b0;

  logic [31:0] snap_grad;
  logic [31:0] snap_deriv;
  logic        snap_valid;
  logic        snap_flag;

  // Reference arithmetic with 64-bit integers.
  function automatic exp_t model(input logic [31:0] y, input logic [31:0] d);
    exp_t   r;
    longint yc;
    longint ysq;
    longint der;
    longint p;
    yc     = longint'($signed(y));
    r.flag = 1'b0;
    if (yc > 64'sd16777216) begin
      yc = 64'sd16777216; r.flag = 1'b1;
    end else if (yc < -64'sd16777216) begin
      yc = -64'sd16777216; r.flag = 1'b1;
    end
    ysq     = (yc * yc) >>> FL;
    der     = 64'sd16777216 - ysq;
    p       = longint'($signed(d)) * der;
    p       = p >>> FL;
    r.deriv = der[31:0];
    r.grad  = p[31:0];
    r.tgt   = 0;
    r.id    = 0;
    return r;
  endfunction

  // Drive one cycle of inputs; queue the expectation if the sample will be
  // captured by the next edge.
  task automatic drive(input bit v, input logic [31:0] y, input logic [31:0] d,
                       input bit e, input bit r, input exp_t x);
    exp_t q;
    rst      = r;
    en       = e;
    in_valid = v;
    y_in     = y;
    delta_in = d;
    if (v && e && !r) begin
      q     = x;
      q.tgt = en_edges + 3;
      q.id  = next_id;
      next_id++;
      sb.push_back(q);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    exp_t z;
    z = model(32'h0, 32'h0);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);
  endtask

  always @(posedge clk) begin
    seen_edge   = 1'b1;
    rst_last    = rst;
    loaded_last = en && !rst;
    if (rst) sb.delete();
    else if (en) en_edges++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (seen_edge) begin
      if (rst_last) begin
        checks++;
        if (out_valid !== 1'b0 || grad_out !== 32'h0 || deriv_out !== 32'h0 || clamp_flag !== 1'b0) begin
          failures++;
          $display("FAIL reset_zero: got valid=%b grad=%h deriv=%h flag=%b, want all zero",
                   out_valid, grad_out, deriv_out, clamp_flag);
        end
      end else if (!loaded_last) begin
        checks++;
        if (out_valid !== snap_valid || grad_out !== snap_grad || deriv_out !== snap_deriv || clamp_flag !== snap_flag) begin
          failures++;
          $display("FAIL stall_hold: got valid=%b grad=%h deriv=%h flag=%b, want valid=%b grad=%h deriv=%h flag=%b",
                   out_valid, grad_out, deriv_out, clamp_flag, snap_valid, snap_grad, snap_deriv, snap_flag);
        end
      end else if (out_valid !== 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got valid=%b grad=%h deriv=%h, want no output", out_valid, grad_out, deriv_out);
        end else begin
          e = sb.pop_front();
          if (out_valid !== 1'b1 || grad_out !== e.grad || deriv_out !== e.deriv || clamp_flag !== e.flag || en_edges != e.tgt) begin
            failures++;
            $display("FAIL sample_%0d: got grad=%h deriv=%h flag=%b edge=%0d, want grad=%h deriv=%h flag=%b edge=%0d",
                     e.id, grad_out, deriv_out, clamp_flag, en_edges, e.grad, e.deriv, e.flag, e.tgt);
          end
        end
      end
      snap_valid = out_valid;
      snap_grad  = grad_out;
      snap_deriv = deriv_out;
      snap_flag  = clamp_flag;
    end
  end

  vec_t tbl[14];

  initial begin
    exp_t z;
    exp_t x;
    logic [31:0] ry;
    logic [31:0] rd;

    tbl[0]  = '{32'h00000000, 32'h01000000, 32'h01000000, 32'h01000000, 1'b0};
    tbl[1]  = '{32'hFF800000, 32'hFE000000, 32'h00C00000, 32'hFE800000, 1'b0};
    tbl[2]  = '{32'h00800000, 32'h01000000, 32'h00C00000, 32'h00C00000, 1'b0};
    tbl[3]  = '{32'h01800000, 32'h03000000, 32'h00000000, 32'h00000000, 1'b1};
    tbl[4]  = '{32'h01000000, 32'h03000000, 32'h00000000, 32'h00000000, 1'b0};
    tbl[5]  = '{32'h00800000, 32'h00000001, 32'h00C00000, 32'h00000000, 1'b0};
    tbl[6]  = '{32'h00800000, 32'hFFFFFFFF, 32'h00C00000, 32'hFFFFFFFF, 1'b0};
    tbl[7]  = '{32'h80000000, 32'h01000000, 32'h00000000, 32'h00000000, 1'b1};
    tbl[8]  = '{32'hFF000000, 32'h05000000, 32'h00000000, 32'h00000000, 1'b0};
    tbl[9]  = '{32'hFEFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1};
    tbl[10] = '{32'h01000001, 32'h01000000, 32'h00000000, 32'h00000000, 1'b1};
    tbl[11] = '{32'h00400000, 32'h02000000, 32'h00F00000, 32'h01E00000, 1'b0};
    tbl[12] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h01000000, 32'h7FFFFFFF, 1'b0};
    tbl[13] = '{32'h00FFFFFF, 32'h80000000, 32'h00000002, 32'hFFFFFF00, 1'b0};

    z = model(32'h0, 32'h0);

    // Reset with en=0: reset must still win.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, z);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, z);

    // Table vectors, back to back.
    for (int i = 0; i < 14; i++) begin
      x.deriv = tbl[i].deriv;
      x.grad  = tbl[i].grad;
      x.flag  = tbl[i].flag;
      x.tgt   = 0;
      x.id    = 0;
      drive(1'b1, tbl[i].y, tbl[i].d, 1'b1, 1'b0, x);
    end
    idle(4);

    // Stream with a 2-cycle stall after the 2nd sample; sample 3 is held on
    // the inputs during the stall and must be captured only once.
    drive(1'b1, 32'h0, 32'h01000000, 1'b1, 1'b0, model(32'h0, 32'h01000000));
    drive(1'b1, 32'h0, 32'h02000000, 1'b1, 1'b0, model(32'h0, 32'h02000000));
    drive(1'b1, 32'h0, 32'h03000000, 1'b0, 1'b0, z);
    drive(1'b1, 32'h0, 32'h03000000, 1'b0, 1'b0, z);
    drive(1'b1, 32'h0, 32'h03000000, 1'b1, 1'b0, model(32'h0, 32'h03000000));
    drive(1'b1, 32'h0, 32'h04000000, 1'b1, 1'b0, model(32'h0, 32'h04000000));
    drive(1'b1, 32'h0, 32'h05000000, 1'b1, 1'b0, model(32'h0, 32'h05000000));
    idle(4);

    // Reset with samples in flight, then a fresh sample.
    drive(1'b1, 32'h00800000, 32'h01000000, 1'b1, 1'b0, model(32'h00800000, 32'h01000000));
    drive(1'b1, 32'hFF800000, 32'hFE000000, 1'b1, 1'b0, model(32'hFF800000, 32'hFE000000));
    drive(1'b1, 32'h01800000, 32'h03000000, 1'b1, 1'b0, model(32'h01800000, 32'h03000000));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, z);
    drive(1'b1, 32'h00400000, 32'h02000000, 1'b1, 1'b0, model(32'h00400000, 32'h02000000));
    idle(5);

    // Random traffic with random stalls.
    for (int i = 0; i < 80; i++) begin
      ry = $urandom();
      ry = $signed(ry) >>> $urandom_range(0, 8);
      rd = $urandom();
      drive(($urandom_range(0, 3) != 0), ry, rd, ($urandom_range(0, 4) != 0), 1'b0, model(ry, rd));
    end
    idle(8);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d samples never produced, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tanh_backward.md
Name: tanh_backward

Overview:
- Backward-pass counterpart of the neuron's pipelined tanh activation.
- Takes the forward output y = tanh(a) and the upstream gradient delta, both Q8.24.
- Produces the local gradient grad = delta * (1 - y^2) for the training/backprop datapath.
- Sits between the error-propagation stage and the weight-update logic. Fully pipelined, one sample per cycle.

Parameters:
- WIDTH, 32, total data width (signed two's complement fixed point)
- FL, 24, fractional bits (Q8.24; 1.0 = 0x01000000)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  pipeline advance enable; 0 freezes every register
- in_valid  input  1  y_in/delta_in carry a valid sample this cycle
- y_in  input  WIDTH  forward tanh output y, signed Q8.24
- delta_in  input  WIDTH  upstream gradient, signed Q8.24
- out_valid  output  1  grad_out/deriv_out/clamp_flag valid
- grad_out  output  WIDTH  delta*(1-y^2), signed Q8.24
- deriv_out  output  WIDTH  (1-y^2), Q8.24, range [0, 0x01000000]
- clamp_flag  output  1  y_in lay outside [-1.0, +1.0] and was clamped

Behaviour:
- Reset: rst=1 at a rising edge clears every pipeline register. out_valid=0, grad_out=0, deriv_out=0, clamp_flag=0 from the next cycle. rst has priority over en.
- Advance: en=1 means all stages load from their predecessors. en=0 means all stages, including valid bits, hold. No sample is lost or duplicated across stalls.
- Latency: 3 enabled cycles from sample capture to out_valid=1. Throughput is 1 sample per enabled cycle.
- Bubbles: in_valid=0 propagates as out_valid=0. Data registers still load. Outputs are don't-care while out_valid=0, except after reset, when they are 0.
- Stage 1:
  - y_c = clamp(y_in, 0xFF000000, 0x01000000).
  - clamped = (y_in > 0x01000000) or (y_in < 0xFF000000).
  - sq_full = y_c*y_c as a 64-bit signed product.
  - y_sq = sq_full[FL+WIDTH-1:FL], i.e. truncation (floor).
  - Register y_sq, delta_in, in_valid, and clamped & in_valid.
- Stage 2:
  - deriv = 0x01000000 - y_sq. Result always in [0, 0x01000000]; no overflow possible.
  - prod = delta_r * deriv as a 64-bit signed product.
  - Register deriv, prod[FL+WIDTH-1:FL] (arithmetic floor shift), valid, and flag.
- Stage 3: output registers drive grad_out, deriv_out, out_valid, clamp_flag.
- No saturation is needed on grad. |deriv| <= 2^FL, so the truncated product always fits WIDTH.
- Rounding: truncation toward negative infinity everywhere. Example: delta=-1 LSB with deriv 0.75 gives grad=0xFFFFFFFF.
- Boundary conditions:
  - y_in = ±1.0 exactly: not flagged; deriv=0, grad=0.
  - y_in = 0x80000000 (most negative): clamped to -1.0 and flagged.
  - rst during a stall: reset wins.
  - en=0 with rst=0: outputs are stable indefinitely.

Test Plan:
- Identity: y_in=0x00000000, delta_in=0x01000000, in_valid=1 at cycle 0 -> cycle 3: out_valid=1, deriv_out=0x01000000, grad_out=0x01000000, clamp_flag=0.
- Mid-range, signed: y_in=0xFF800000 (-0.5), delta_in=0xFE000000 (-2.0) -> deriv_out=0x00C00000, grad_out=0xFE800000 (-1.5). With y_in=0x00800000 and delta_in=0x01000000 -> grad_out=0x00C00000.
- Clamp: y_in=0x01800000 (1.5), delta_in=0x03000000 -> deriv_out=0, grad_out=0, clamp_flag=1. y_in=0x01000000 -> same outputs but clamp_flag=0.
- Truncation: y_in=0x00800000, delta_in=0x00000001 -> grad_out=0x00000000. delta_in=0xFFFFFFFF -> grad_out=0xFFFFFFFF.
- Stall/stream:
  - Stimulus: back-to-back samples with y=0, delta=1,2,3,4,5 (×0x01000000). Drop en for 2 cycles after the 2nd sample is captured.
  - Required: outputs frozen during the stall; the 5 results appear in order, each exactly once, with a valid gap only where en=0.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight and en=1 -> next cycle out_valid=0, grad_out=0, deriv_out=0, clamp_flag=0. A sample injected after reset emerges 3 cycles later, correct.
